// File: rtl/act_pkg.sv
// Shared types for the act_stream activation stage: activation modes, FSM states
// and the width helper for the optional zero counter.
package act_pkg;

    typedef enum logic [1:0] {
        RELU   = 2'd0,
        LEAKY  = 2'd1,
        CLAMP  = 2'd2,
        BYPASS = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } act_state_t;

    // Wide enough to hold every count from 0 to dim inclusive.
    function automatic int zc_width(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/act_stream_if.sv
// Handshake and vector bus for act_stream. The zero_count signal exists only
// when ACT_STREAM_SPARSITY_EN is defined.
interface act_stream_if
    import act_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIM    = 16
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] vec_in [DIM];
    logic [1:0]               mode;
    logic signed [DATA_W-1:0] clip_max;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] vec_out [DIM];
    logic                     busy;

`ifdef ACT_STREAM_SPARSITY_EN
    logic [zc_width(DIM)-1:0] zero_count;

    modport slave (
        input  in_valid, vec_in, mode, clip_max, out_ready,
        output in_ready, out_valid, vec_out, busy, zero_count
    );

    modport master (
        output in_valid, vec_in, mode, clip_max, out_ready,
        input  in_ready, out_valid, vec_out, busy, zero_count
    );
`else
    modport slave (
        input  in_valid, vec_in, mode, clip_max, out_ready,
        output in_ready, out_valid, vec_out, busy
    );

    modport master (
        output in_valid, vec_in, mode, clip_max, out_ready,
        input  in_ready, out_valid, vec_out, busy
    );
`endif

endinterface

// File: rtl/act_lane.sv
// Single-element activation: purely combinational, one instance per lane.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    input  act_mode_t                mode,
    input  logic signed [DATA_W-1:0] clip_max,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [DATA_W-1:0] ZERO = '0;

    always_comb begin
        y = x;
        case (mode)
            RELU:   y = (x > ZERO) ? x : ZERO;
            LEAKY:  y = (x >= ZERO) ? x : (x >>> LEAK_SHIFT);
            CLAMP: begin
                // A negative ceiling forces zero even for positive inputs.
                if (x <= ZERO || clip_max < ZERO) begin
                    y = ZERO;
                end else if (x > clip_max) begin
                    y = clip_max;
                end else begin
                    y = x;
                end
            end
            BYPASS: y = x;
            default: y = x;
        endcase
    end

endmodule

// File: rtl/act_stream.sv
// Vector activation stage: buffers one DIM-element vector and emits LANES results
// per cycle into a registered output. ACT_STREAM_SPARSITY_EN adds zero_count.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// BUSY  | computing one beat of LANES elements per cycle
// DONE  | result complete, out_valid high until out_ready
module act_stream
    import act_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIM        = 16,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input logic         clk,
    input logic         rst_n,
    act_stream_if.slave io
);

    localparam int BEATS  = DIM / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (LANES < 1 || (DIM % LANES) != 0) begin : g_bad_cfg
            $error("act_stream: DIM must be a non-zero multiple of LANES");
        end
    endgenerate

    act_state_t               state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic signed [DATA_W-1:0] buf_q [DIM];
    logic signed [DATA_W-1:0] buf_d [DIM];
    act_mode_t                mode_q, mode_d;
    logic signed [DATA_W-1:0] clip_q, clip_d;
    logic signed [DATA_W-1:0] vout_q [DIM];
    logic signed [DATA_W-1:0] vout_d [DIM];
    logic signed [DATA_W-1:0] lane_x [LANES];
    logic signed [DATA_W-1:0] lane_y [LANES];
    logic                     accept;

    assign io.in_ready  = (state_q == IDLE) || (state_q == DONE && io.out_ready);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q == BUSY);
    assign io.vec_out   = vout_q;
    assign accept       = io.in_valid && io.in_ready;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = buf_q[l];
        end
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_x[l] = buf_q[b*LANES + l];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            act_lane #(
                .DATA_W     (DATA_W),
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_lane (
                .x        (lane_x[g]),
                .mode     (mode_q),
                .clip_max (clip_q),
                .y        (lane_y[g])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        clip_d  = clip_q;
        vout_d  = vout_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                beat_d = beat_q + 1'b1;
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_q == BEAT_W'(b)) begin
                        for (int l = 0; l < LANES; l++) begin
                            vout_d[b*LANES + l] = lane_y[l];
                        end
                    end
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                    beat_d  = '0;
                end
            end
            DONE: begin
                // Output handshake with a waiting vector restarts without a bubble.
                if (io.out_ready) state_d = io.in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            buf_d  = io.vec_in;
            mode_d = act_mode_t'(io.mode);
            clip_d = io.clip_max;
            beat_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            mode_q  <= RELU;
            clip_q  <= '0;
            for (int i = 0; i < DIM; i++) begin
                buf_q[i]  <= '0;
                vout_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            clip_q  <= clip_d;
            buf_q   <= buf_d;
            vout_q  <= vout_d;
        end
    end

`ifdef ACT_STREAM_SPARSITY_EN
    localparam int ZC_W = zc_width(DIM);

    logic [ZC_W-1:0] zc_q, zc_d;

    assign io.zero_count = zc_q;

    always_comb begin
        zc_d = zc_q;
        if (state_q == BUSY) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_y[l] == '0) zc_d = zc_d + 1'b1;
            end
        end
        if (accept) zc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zc_q <= '0;
        end else begin
            zc_q <= zc_d;
        end
    end
`endif

endmodule
